imem_fetch_sequencer: RTL and testbench

Fetch controller for the non-pipelined MIPS core. It owns the program counter and drives the word address of the synchronous 256 x 32 instruction memory, whose read data appears one clock after the address. It presents each fetched word to the multi-cycle execute logic through a valid/ready handshake, then waits for execute to finish. On completion it either advances sequentially or redirects to a branch or jump target.

---
 rtl/imem_fetch_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_imem_fetch_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer
// Owns the program counter of the non-pipelined MIPS core. It fetches one
// word at a time from a synchronous instruction memory (one-cycle read
// latency) and hands it to the multi-cycle execute logic over valid/ready.
// It then waits for execute to finish, and either advances to pc+4 or
// redirects to a branch/jump target. HALTED and FAULT are terminal states;
// only reset leaves them.

module imem_fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          halt,
  output logic [$clog2(MEM_WORDS)-1:0]  mem_addr,
  input  logic [31:0]                   mem_rdata,
  output logic [31:0]                   instr,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  input  logic                          exec_done,
  input  logic                          redirect_en,
  input  logic [31:0]                   redirect_pc,
  output logic [31:0]                   pc,
  output logic                          busy,
  output logic                          fault,
  output logic [31:0]                   retired
);

  // Width of the word address, and the first byte-address bit above the
  // memory space. Any target with a bit set at or above TOP_BIT is out of range.
  localparam int unsigned AW      = $clog2(MEM_WORDS);
  localparam int unsigned TOP_BIT = AW + 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_VALID  = 3'd3,
    S_EXEC   = 3'd4,
    S_HALTED = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  // A legal next PC is word aligned and lies inside the instruction memory.
  // pc+4 from the last word therefore fails this check; it does not wrap.
  function automatic logic target_ok(input logic [31:0] target);
    target_ok = (target[1:0] == 2'b00) && ((target >> TOP_BIT) == 32'h0000_0000);
  endfunction

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic        instr_valid_r;
  logic        busy_r;
  logic        fault_r;
  logic [31:0] retired_r;

  logic [31:0] next_pc_s;
  logic        load_pc_s;
  logic        capture_s;
  logic        retire_s;

  // Next-state logic, target selection and the datapath enables.
  always_comb begin
    next_state_s = state_r;
    load_pc_s    = 1'b0;
    capture_s    = 1'b0;
    retire_s     = 1'b0;
    if (redirect_en) begin
      next_pc_s = redirect_pc;
    end else begin
      next_pc_s = pc_r + 32'd4;
    end

    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        // mem_addr is already presented from pc; the memory samples it now.
        next_state_s = S_FETCH == state_r ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        capture_s    = 1'b1;
        next_state_s = S_VALID;
      end
      S_VALID: begin
        // instr_valid is high throughout VALID, so ready alone completes the transfer.
        if (instr_ready) begin
          next_state_s = S_EXEC;
        end else begin
          next_state_s = S_VALID;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          retire_s = 1'b1;
          if (halt) begin
            next_state_s = S_HALTED;
          end else if (!target_ok(next_pc_s)) begin
            next_state_s = S_FAULT;
          end else begin
            load_pc_s    = 1'b1;
            next_state_s = S_FETCH;
          end
        end else begin
          next_state_s = S_EXEC;
        end
      end
      S_HALTED: begin
        next_state_s = S_HALTED;
      end
      S_FAULT: begin
        next_state_s = S_FAULT;
      end
      default: begin
        // An unused encoding can only come from an upset; recover to IDLE.
        next_state_s = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Program counter: it changes only on a successful in-range completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (load_pc_s) begin
      pc_r <= next_pc_s;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Instruction capture on the closing edge of WAIT; held through VALID and EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_r <= 32'h0000_0000;
    end else if (capture_s) begin
      instr_r <= mem_rdata;
    end else begin
      instr_r <= instr_r;
    end
  end

  // Retired counter: one per accepted exec_done, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_r <= 32'h0000_0000;
    end else if (retire_s) begin
      retired_r <= retired_r + 32'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  // Status outputs are decoded from the next state so that they are registered
  // and still line up cycle-for-cycle with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      fault_r       <= 1'b0;
    end else begin
      instr_valid_r <= (next_state_s == S_VALID);
      busy_r        <= (next_state_s inside {S_FETCH, S_WAIT, S_VALID, S_EXEC});
      fault_r       <= (next_state_s == S_FAULT);
    end
  end

  assign mem_addr    = pc_r[AW+1:2];
  assign pc          = pc_r;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign busy        = busy_r;
  assign fault       = fault_r;
  assign retired     = retired_r;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Testbench for imem_fetch_sequencer. A table of per-instruction records is
// applied in a loop, and fetched words are checked against a scoreboard
// queue. Hand-written sequences cover the async reset in WAIT and the
// inputs that the block must ignore.

module tb_imem_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halt;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        exec_done;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        busy;
  logic        fault;
  logic [31:0] retired;

  always #5 clk = ~clk;

  imem_fetch_sequencer #(.RESET_PC(RESET_PC), .MEM_WORDS(256)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .exec_done(exec_done), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .pc(pc), .busy(busy), .fault(fault), .retired(retired)
  );

  // Synchronous instruction memory with a one-cycle read latency
  logic [31:0] mem [0:255];
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          new_run;
    int          bp;
    logic        rd_en;
    logic [31:0] rd_pc;
    logic        hlt;
    logic [31:0] exp_pc;
    logic        exp_fault;
    logic        exp_term;
    logic [31:0] exp_ret;
  } vec_t;
  vec_t vecs[11];

  function automatic vec_t mkv(input bit nr, input int bp, input logic re, input logic [31:0] rp,
                               input logic h, input logic [31:0] ep, input logic ef,
                               input logic et, input logic [31:0] er);
    vec_t v;
    v.new_run = nr; v.bp = bp; v.rd_en = re; v.rd_pc = rp; v.hlt = h;
    v.exp_pc = ep; v.exp_fault = ef; v.exp_term = et; v.exp_ret = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Optional reset, then a start pulse. Checks the reset values and the fetch latency.
  task automatic start_run(input bit do_rst);
    if (do_rst) begin
      reset = 1'b1; start = 1'b0; exec_done = 1'b0; redirect_en = 1'b0; halt = 1'b0;
      #1;
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_retired", retired, 32'd0);
      chk("rst_pc", pc, RESET_PC);
      chk("rst_instr", instr, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();
    end
    sb.delete();
    sb.push_back('{pc: RESET_PC, instr: mem[RESET_PC[9:2]]});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat_c1_busy", {31'd0, busy}, 32'd1);
    chk("lat_c1_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("lat_c2_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    chk("lat_c3_valid", {31'd0, instr_valid}, 32'd1);
  endtask

  // Wait (bounded) for instr_valid, then compare against the scoreboard head.
  task automatic wait_and_check(output exp_t e);
    int k;
    k = 0;
    e = '0;
    while (instr_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("valid_timeout", {31'd0, instr_valid}, 32'd1);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_empty: got no expected entry, want one");
    end else begin
      e = sb.pop_front();
      chk("sb_pc", pc, e.pc);
      chk("sb_instr", instr, e.instr);
      chk("sb_mem_addr", {24'd0, mem_addr}, {24'd0, e.pc[9:2]});
    end
  endtask

  // Hold ready low for bp cycles (with a stray exec_done), then complete the transfer.
  task automatic handshake(input int bp, input exp_t e, input logic [31:0] ret_before);
    for (int k = 0; k < bp; k++) begin
      instr_ready = 1'b0;
      exec_done = (k == 2);
      tick();
      exec_done = 1'b0;
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_instr", instr, e.instr);
      chk("bp_pc", pc, e.pc);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      chk("bp_retired", retired, ret_before);
    end
    instr_ready = 1'b1;
    tick();
    chk("xfer_valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("xfer_busy", {31'd0, busy}, 32'd1);
  endtask

  initial begin : main
    exp_t e;
    vec_t v;
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    reset = 1'b1; start = 1'b0; halt = 1'b0; instr_ready = 1'b1;
    exec_done = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0000_0000;

    vecs[0]  = mkv(1'b1, 0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 32'd1);
    vecs[1]  = mkv(1'b0, 5, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 32'd2);
    vecs[2]  = mkv(1'b0, 0, 1'b0, 32'h0000_0100, 1'b0, 32'h0000_000C, 1'b0, 1'b0, 32'd3);
    vecs[3]  = mkv(1'b0, 0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 32'd4);
    vecs[4]  = mkv(1'b1, 0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 32'd1);
    vecs[5]  = mkv(1'b0, 0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 32'd2);
    vecs[6]  = mkv(1'b0, 0, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0020, 1'b0, 1'b0, 32'd3);
    vecs[7]  = mkv(1'b0, 0, 1'b1, 32'h0000_0022, 1'b0, 32'h0000_0020, 1'b1, 1'b1, 32'd4);
    vecs[8]  = mkv(1'b1, 0, 1'b1, 32'h0000_03FC, 1'b0, 32'h0000_03FC, 1'b0, 1'b0, 32'd1);
    vecs[9]  = mkv(1'b0, 0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_03FC, 1'b1, 1'b1, 32'd2);
    vecs[10] = mkv(1'b1, 0, 1'b1, 32'h0000_0401, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'd1);

    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      instr_ready = (v.bp == 0);
      if (v.new_run) start_run(1'b1);
      wait_and_check(e);
      handshake(v.bp, e, v.exp_ret - 32'd1);
      exec_done = 1'b1; redirect_en = v.rd_en; redirect_pc = v.rd_pc; halt = v.hlt;
      tick();
      exec_done = 1'b0; redirect_en = 1'b0; halt = 1'b0; redirect_pc = 32'h0000_0000;
      chk("done_retired", retired, v.exp_ret);
      chk("done_pc", pc, v.exp_pc);
      chk("done_mem_addr", {24'd0, mem_addr}, {24'd0, v.exp_pc[9:2]});
      chk("done_fault", {31'd0, fault}, {31'd0, v.exp_fault});
      chk("done_busy", {31'd0, busy}, {31'd0, ~v.exp_term});
      if (!v.exp_term) begin
        sb.push_back('{pc: v.exp_pc, instr: mem[v.exp_pc[9:2]]});
      end else begin
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("term_busy", {31'd0, busy}, 32'd0);
        chk("term_valid", {31'd0, instr_valid}, 32'd0);
        chk("term_fault", {31'd0, fault}, {31'd0, v.exp_fault});
        chk("term_pc", pc, v.exp_pc);
        chk("term_retired", retired, v.exp_ret);
      end
    end

    // Async reset asserted in WAIT, between clock edges
    instr_ready = 1'b1;
    start_run(1'b1);
    wait_and_check(e);
    handshake(0, e, 32'd0);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("ar_retired_pre", retired, 32'd1);
    chk("ar_pc_pre", pc, 32'h0000_0004);
    tick();
    chk("ar_busy_wait", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", {31'd0, instr_valid}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_retired", retired, 32'd0);
    chk("ar_pc", pc, RESET_PC);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exec_done = (k == 1);
      tick();
      exec_done = 1'b0;
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_valid", {31'd0, instr_valid}, 32'd0);
      chk("idle_retired", retired, 32'd0);
    end
    start_run(1'b0);
    wait_and_check(e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "timeout");
  end

endmodule
